block_ram_loader: RTL and testbench
===================================

Name: block_ram_loader

Overview:
- Write-port controller for the 16-entry, 32x32 tetromino sprite RAM (14-bit write address = {sid[3:0], row[4:0], col[4:0]}).
- Sequences bulk copies of sprite images from an external pattern ROM into the RAM.
- Shares the single RAM write port (we/addr_w/pixel_in) with a processor write requester.
- Sits between the boot/config logic and the block sprite source; the read side of the sprite RAM is untouched.

Parameters:
- CD, 12, colour depth (bits per pixel).
- ADDR, 14, sprite RAM / ROM address width.
- SPR_BITS, 10, address bits per sprite (32x32 = 1024 words).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begin bulk load
- sid_first  in  4  first sprite id to load (sampled on accepted start)
- sid_last  in  4  last sprite id to load, inclusive (sampled on accepted start)
- rom_addr  out  ADDR  pattern ROM read address
- rom_data  in  CD  pattern ROM data; valid exactly 1 cycle after rom_addr
- cpu_wr  in  1  processor write request; held until cpu_ack
- cpu_addr  in  ADDR  processor write address
- cpu_data  in  CD  processor write pixel
- cpu_ack  out  1  one-cycle acknowledge; write accepted
- vblank  in  1  vertical blanking flag (used only with the optional feature)
- we  out  1  sprite RAM write enable (registered)
- addr_w  out  ADDR  sprite RAM write address (registered)
- pixel_in  out  CD  sprite RAM write data (registered)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at load completion

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - Outputs: we=0, addr_w=0, pixel_in=0, rom_addr=0, cpu_ack=0, busy=0, done=0.
  - Counters and pipeline valid flags cleared.
  - Reset mid-load abandons the load with no done pulse; RAM contents are left partial.
- FSM states: IDLE, LOAD, DRAIN, FIN.
- IDLE:
  - start=1: latch sid range; cnt={sid_first,10'h000}; busy=1 next cycle; go LOAD.
  - start=1 with sid_first>sid_last: go FIN directly; zero writes.
  - cpu_wr=1 and no start: register the write. Next cycle we=1, addr_w=cpu_addr, pixel_in=cpu_data, cpu_ack=1.
  - A back-to-back cpu_wr is accepted no earlier than the cycle after cpu_ack (1 write per 2 cycles).
  - start and cpu_wr in the same cycle: start wins; cpu_wr stays pending (requester holds it) until IDLE is re-entered.
- LOAD:
  - rom_addr=cnt; cnt increments by 1 per issue cycle.
  - Read-valid flag delays 1 cycle. The write stage then drives we=1, addr_w=issued address, pixel_in=rom_data.
  - Latency: rom_addr presented in cycle n gives we in cycle n+2.
  - Issue of {sid_last,10'h3FF} → DRAIN. Sequential wrap from xx3FF to (xx+1)000 is normal carry.
  - cnt is 15 bits internally so that sid_last=15 does not wrap to 0.
  - start and cpu_wr are ignored while busy; cpu_ack stays 0.
- DRAIN: no new issues. Wait until the last write has been driven (2 cycles), then go FIN.
- FIN: done=1 for exactly one cycle; busy=0 in the same cycle; next state IDLE.
- Total writes per load: 1024 × (sid_last − sid_first + 1), each address written exactly once, in ascending order.
- Writes are never issued with X data; the write stage is gated by the valid flag only.

Optional Feature:
- Macro: BLOCK_LOADER_VBLANK_GATE_EN.
- Defined:
  - LOAD issues new ROM reads only while vblank=1; cnt and rom_addr hold while vblank=0.
  - Reads already in flight still complete, so at most 2 writes occur after vblank falls.
  - CPU writes are accepted only while vblank=1.
  - Load resumes at the held address when vblank returns, with no skipped or duplicated addresses.
- Not defined: vblank is ignored; LOAD issues every cycle.

Test Plan:
- Reset mid-LOAD (sid 0..0, after 100 writes) → all outputs 0 immediately; no done; IDLE accepts a new start afterwards.
- start, sid_first=2, sid_last=2, ROM returns data=addr[11:0] → exactly 1024 writes to addr 0x0800..0x0BFF, pixel_in=addr[11:0]. First we is 2 cycles after the first rom_addr. done pulses 1 cycle after the last we; busy high throughout.
- start, sid_first=14, sid_last=15 → 2048 writes 0x3800..0x3FFF, no wrap to 0x0000; single done pulse.
- start, sid_first=5, sid_last=3 → no we; done pulses 1 cycle later; busy never high after that cycle.
- cpu_wr addr=0x0123, data=0xABC in IDLE → next cycle we=1, addr_w=0x0123, pixel_in=0xABC, cpu_ack=1.
- cpu_wr asserted simultaneously with start (sid 0..0) → no cpu_ack during the load; the CPU write occurs after done.
- With BLOCK_LOADER_VBLANK_GATE_EN: vblank toggles every 37 cycles during a 1-sprite load → all 1024 addresses written once, in order; at most 2 we while vblank=0 per low period.

Source files
------------

// File: rtl/block_ram_loader.sv
// block_ram_loader
// Write-port controller for the 16-entry 32x32 tetromino sprite RAM.
// It copies whole sprite images from an external pattern ROM into the RAM
// and shares the single RAM write port with a processor write requester.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               one-cycle pulse: begin a bulk load
//   sid_first/sid_last  inclusive sprite id range, sampled on accepted start
//   rom_addr / rom_data pattern ROM read address / data (data 1 cycle later)
//   cpu_wr/addr/data    processor write request, held until cpu_ack
//   cpu_ack             one-cycle acknowledge of a processor write
//   vblank              vertical blanking (only used with the gate option)
//   we/addr_w/pixel_in  registered sprite RAM write port
//   busy, done          load in progress / one-cycle completion pulse
//
// Option: define BLOCK_LOADER_VBLANK_GATE_EN to restrict ROM reads and CPU
// writes to vertical blanking. Default build ignores vblank.
module block_ram_loader #(
  parameter int CD       = 12,
  parameter int ADDR     = 14,
  parameter int SPR_BITS = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [3:0]      sid_first,
  input  logic [3:0]      sid_last,
  output logic [ADDR-1:0] rom_addr,
  input  logic [CD-1:0]   rom_data,
  input  logic            cpu_wr,
  input  logic [ADDR-1:0] cpu_addr,
  input  logic [CD-1:0]   cpu_data,
  output logic            cpu_ack,
  input  logic            vblank,
  output logic            we,
  output logic [ADDR-1:0] addr_w,
  output logic [CD-1:0]   pixel_in,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FIN} state_e;

  state_e          state_q, state_d;
  // One extra bit so the count past {15,3FF} does not alias to address 0.
  logic [ADDR:0]   cnt_q, cnt_d;
  logic [ADDR:0]   last_q, last_d;
  logic            rd_vld_q, rd_vld_d;
  logic [ADDR-1:0] rd_addr_q, rd_addr_d;
  logic            we_q, we_d;
  logic [ADDR-1:0] addr_w_q, addr_w_d;
  logic [CD-1:0]   pixel_q, pixel_d;
  logic            ack_q, ack_d;
  logic            gate_ok;
  logic            cpu_acc;

`ifdef BLOCK_LOADER_VBLANK_GATE_EN
  assign gate_ok = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign gate_ok       = 1'b1;
`endif

  // ack_q blocks a re-accept in the acknowledge cycle, where the requester
  // is still holding cpu_wr for the write just taken.
  assign cpu_acc = (state_q == IDLE) && !start && cpu_wr && !ack_q && gate_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    rd_vld_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    we_d      = 1'b0;
    addr_w_d  = addr_w_q;
    pixel_d   = pixel_q;
    ack_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = {1'b0, sid_first, {SPR_BITS{1'b0}}};
          last_d  = {1'b0, sid_last, {SPR_BITS{1'b1}}};
          state_d = (sid_first > sid_last) ? FIN : LOAD;
        end
      end
      LOAD: begin
        if (gate_ok) begin
          cnt_d     = cnt_q + 1'b1;
          rd_vld_d  = 1'b1;
          rd_addr_d = cnt_q[ADDR-1:0];
          if (cnt_q == last_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Last read is in the write stage once rd_vld_q has cleared.
        if (!rd_vld_q) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Write stage: ROM data takes the port whenever a read is in flight;
    // CPU writes only get in while IDLE, when no read can be pending.
    if (rd_vld_q) begin
      we_d     = 1'b1;
      addr_w_d = rd_addr_q;
      pixel_d  = rom_data;
    end else if (cpu_acc) begin
      we_d     = 1'b1;
      addr_w_d = cpu_addr;
      pixel_d  = cpu_data;
      ack_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      we_q      <= 1'b0;
      addr_w_q  <= '0;
      pixel_q   <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      we_q      <= we_d;
      addr_w_q  <= addr_w_d;
      pixel_q   <= pixel_d;
      ack_q     <= ack_d;
    end
  end

  assign rom_addr = cnt_q[ADDR-1:0];
  assign we       = we_q;
  assign addr_w   = addr_w_q;
  assign pixel_in = pixel_q;
  assign cpu_ack  = ack_q;
  assign busy     = (state_q == LOAD) || (state_q == DRAIN);
  assign done     = (state_q == FIN);

endmodule

// File: tb/tb_block_ram_loader.sv
// Directed bench for block_ram_loader: pattern ROM returns addr[11:0].
module tb_block_ram_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  sid_first = '0;
  logic [3:0]  sid_last = '0;
  logic [13:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic        cpu_wr = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [11:0] cpu_data = '0;
  logic        cpu_ack;
  logic        vblank = 1'b1;
  logic        we;
  logic [13:0] addr_w;
  logic [11:0] pixel_in;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail = 0;

  block_ram_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .sid_first(sid_first), .sid_last(sid_last),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_ack(cpu_ack), .vblank(vblank),
    .we(we), .addr_w(addr_w), .pixel_in(pixel_in),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pattern ROM: one-cycle read latency, data = address[11:0].
  always @(posedge clk) rom_data <= rom_addr[11:0];

  task automatic check_idle_outs(input string name);
    n_checks++;
    if ({we, addr_w, pixel_in, rom_addr, cpu_ack, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL %s: we=%b addr_w=%h pix=%h rom=%h ack=%b busy=%b done=%b required all 0",
               name, we, addr_w, pixel_in, rom_addr, cpu_ack, busy, done);
    end
  endtask

  task automatic test_reset;
    #2;
    check_idle_outs("reset_state");
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    check_idle_outs("after_reset_release");
  endtask

  task automatic test_reset_mid_load;
    int nw = 0;
    int bad = 0;
    @(negedge clk) begin sid_first = 4'd0; sid_last = 4'd0; start = 1'b1; end
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 300 && nw < 100; c++) begin
      @(negedge clk);
      if (we) nw++;
    end
    n_checks++;
    if (nw != 100) begin n_fail++; $display("FAIL mid_reset_setup: writes %0d required 100", nw); end
    reset_n = 1'b0;
    #1;
    check_idle_outs("mid_load_reset");
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || we || busy) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL no_done_after_reset: bad cycles %0d required 0", bad); end
  endtask

  // Bulk load f..l; optionally toggles vblank every 37 cycles.
  task automatic test_load(input logic [3:0] f, input logic [3:0] l, input bit tog);
    logic [13:0] exp;
    int nw = 0, first_we = -1, last_we = -1, done_c = -1;
    int bad_wr = 0, bad_busy = 0, low = 0, max_low = 0;
    int want = (int'(l) - int'(f) + 1) * 1024;
    exp = {f, 10'h000};
    @(negedge clk) begin sid_first = f; sid_last = l; start = 1'b1; end
    @(negedge clk) start = 1'b0;
    n_checks++;
    if (rom_addr !== {f, 10'h000} || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_first_issue: rom_addr=%h busy=%b required %h 1", rom_addr, busy, {f, 10'h000});
    end
    for (int c = 0; c < 6000; c++) begin
      if (c > 0) @(negedge clk);
      if (we) begin
        if (addr_w !== exp || pixel_in !== exp[11:0]) begin
          if (bad_wr == 0)
            $display("FAIL load_write: addr_w=%h pix=%h required %h %h", addr_w, pixel_in, exp, exp[11:0]);
          bad_wr++;
        end
        if (first_we < 0) first_we = c;
        last_we = c;
        nw++;
        exp = exp + 14'd1;
        if (!vblank) begin low++; if (low > max_low) max_low = low; end
      end
      if (done) begin done_c = c; break; end
      if (busy !== 1'b1) bad_busy++;
      if (tog && (c % 37) == 36) begin vblank = ~vblank; low = 0; end
    end
    vblank = 1'b1;
    n_checks++;
    if (bad_wr != 0) begin n_fail++; $display("FAIL load_data: bad writes %0d required 0", bad_wr); end
    n_checks++;
    if (done_c < 0) begin n_fail++; $display("FAIL load_timeout: no done within budget"); end
    n_checks++;
    if (nw != want) begin n_fail++; $display("FAIL load_count: writes %0d required %0d", nw, want); end
    n_checks++;
    if (done_c != last_we + 1) begin n_fail++; $display("FAIL done_timing: done at %0d required %0d", done_c, last_we + 1); end
    n_checks++;
    if (bad_busy != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_window: bad cycles %0d busy_at_done=%b required 0 0", bad_busy, busy);
    end
    if (!tog) begin
      n_checks++;
      if (first_we != 2) begin n_fail++; $display("FAIL first_we_latency: %0d required 2", first_we); end
    end else begin
      n_checks++;
      if (max_low > 2) begin n_fail++; $display("FAIL vblank_low_writes: %0d required <=2", max_low); end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL done_single_pulse: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_empty_range;
    int bad = 0;
    @(negedge clk) begin sid_first = 4'd5; sid_last = 4'd3; start = 1'b1; end
    @(negedge clk) start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || we !== 1'b0) begin
      n_fail++; $display("FAIL empty_done: done=%b busy=%b we=%b required 1 0 0", done, busy, we);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy || we || done) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL empty_quiet: bad cycles %0d required 0", bad); end
  endtask

  task automatic test_cpu_write;
    @(negedge clk) begin cpu_wr = 1'b1; cpu_addr = 14'h0123; cpu_data = 12'hABC; end
    @(negedge clk);
    n_checks++;
    if (we !== 1'b1 || addr_w !== 14'h0123 || pixel_in !== 12'hABC || cpu_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL cpu_write: we=%b addr=%h pix=%h ack=%b required 1 0123 abc 1", we, addr_w, pixel_in, cpu_ack);
    end
    cpu_wr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (we !== 1'b0 || cpu_ack !== 1'b0) begin
      n_fail++; $display("FAIL cpu_write_end: we=%b ack=%b required 0 0", we, cpu_ack);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] acks, wes;
    @(negedge clk) begin cpu_wr = 1'b1; cpu_addr = 14'h0200; cpu_data = 12'h321; end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      acks[c] = cpu_ack;
      wes[c] = we;
    end
    cpu_wr = 1'b0;
    n_checks++;
    if (acks !== 4'b0101 || wes !== 4'b0101) begin
      n_fail++; $display("FAIL back_to_back: ack=%b we=%b required 0101 0101", acks, wes);
    end
    @(negedge clk);
    n_checks++;
    if (we !== 1'b0 || cpu_ack !== 1'b0) begin
      n_fail++; $display("FAIL back_to_back_end: we=%b ack=%b required 0 0", we, cpu_ack);
    end
  endtask

  task automatic test_start_with_cpu;
    int acks = 0;
    bit got_done = 0;
    @(negedge clk) begin
      sid_first = 4'd0; sid_last = 4'd0; start = 1'b1;
      cpu_wr = 1'b1; cpu_addr = 14'h0055; cpu_data = 12'h123;
    end
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (c > 0) @(negedge clk);
      if (cpu_ack) acks++;
      if (done) begin got_done = 1; break; end
    end
    n_checks++;
    if (!got_done || acks != 0) begin
      n_fail++; $display("FAIL start_wins: done_seen=%0d acks=%0d required 1 0", got_done, acks);
    end
    @(negedge clk);
    n_checks++;
    if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL cpu_after_done_early: ack=%b required 0", cpu_ack); end
    @(negedge clk);
    n_checks++;
    if (we !== 1'b1 || addr_w !== 14'h0055 || pixel_in !== 12'h123 || cpu_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL cpu_after_done: we=%b addr=%h pix=%h ack=%b required 1 0055 123 1", we, addr_w, pixel_in, cpu_ack);
    end
    cpu_wr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_load(4'd2, 4'd2, 1'b0);
    test_load(4'd14, 4'd15, 1'b0);
    test_empty_range();
    test_cpu_write();
    test_back_to_back();
    test_start_with_cpu();
`ifdef BLOCK_LOADER_VBLANK_GATE_EN
    test_load(4'd0, 4'd0, 1'b1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
